// File: rtl/arb_grant_sequencer.sv
// arb_grant_sequencer: serializes granted client commands onto a shared memory port
// with a ready handshake, a per-command timeout guard and per-client completion pulses.
`default_nettype none

module arb_grant_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        grant,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic [DATA_W-1:0] c1_wdata,
  input  logic              c0_we,
  input  logic              c1_we,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              c0_done,
  output logic              c1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [1:0]        pending;
  logic              sel;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] lat_addr0, lat_addr1;
  logic [DATA_W-1:0] lat_wdata0, lat_wdata1;
  logic              lat_we0, lat_we1;
  logic [1:0]        rem;

  // Pending set once the client currently being served is retired.
  assign rem = sel ? {1'b0, pending[0]} : {pending[1], 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pending    <= 2'b00;
      sel        <= 1'b0;
      cnt        <= 8'd0;
      lat_addr0  <= '0;
      lat_addr1  <= '0;
      lat_wdata0 <= '0;
      lat_wdata1 <= '0;
      lat_we0    <= 1'b0;
      lat_we1    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      c0_done    <= 1'b0;
      c1_done    <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      c0_done <= 1'b0;
      c1_done <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            pending    <= grant;
            lat_addr0  <= c0_addr;
            lat_addr1  <= c1_addr;
            lat_wdata0 <= c0_wdata;
            lat_wdata1 <= c1_wdata;
            lat_we0    <= c0_we;
            lat_we1    <= c1_we;
            sel        <= ~grant[0];
            cnt        <= 8'd0;
            mem_req    <= 1'b1;
            mem_addr   <= grant[0] ? c0_addr  : c1_addr;
            mem_wdata  <= grant[0] ? c0_wdata : c1_wdata;
            mem_we     <= grant[0] ? c0_we    : c1_we;
            busy       <= 1'b1;
            state      <= SERVE;
          end
        end

        SERVE: begin
          // Ready is checked first so a ready on the final allowed cycle succeeds.
          if (mem_ready) begin
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
            mem_req <= 1'b0;
            c0_done <= ~sel;
            c1_done <= sel;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            c0_done <= ~sel;
            c1_done <= sel;
            err     <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        DONE: begin
          cnt     <= 8'd0;
          pending <= rem;
          if (rem != 2'b00) begin
            sel       <= ~rem[0];
            mem_req   <= 1'b1;
            mem_addr  <= rem[0] ? lat_addr0  : lat_addr1;
            mem_wdata <= rem[0] ? lat_wdata0 : lat_wdata1;
            mem_we    <= rem[0] ? lat_we0    : lat_we1;
            state     <= SERVE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          pending <= 2'b00;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arb_grant_sequencer.sv
// Self-checking bench for arb_grant_sequencer: directed vector table, reset corner case
// and randomized transactions checked against a transaction-level timeline model.
`default_nettype none

module tb_arb_grant_sequencer;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  grant = 2'b00;
  logic [15:0] c0_addr = '0, c1_addr = '0, c0_wdata = '0, c1_wdata = '0;
  logic        c0_we = 1'b0, c1_we = 1'b0;
  logic        mem_req, mem_we, mem_ready = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        c0_done, c1_done, err, busy;
  logic [15:0] rdata;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rdata = '0;

  arb_grant_sequencer #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .grant(grant),
    .c0_addr(c0_addr), .c1_addr(c1_addr),
    .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .c0_we(c0_we), .c1_we(c1_we),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .c0_done(c0_done), .c1_done(c1_done), .rdata(rdata), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  g;
    logic [15:0] a0, d0;
    logic        we0;
    logic [15:0] a1, d1;
    logic        we1;
    int          w0, w1;
    logic [15:0] rv;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_done"}, 32'({c1_done, c0_done}), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Timeline model: each granted client, c0 first, occupies SERVE for (wait+1) cycles
  // when ready comes within TIMEOUT cycles, otherwise TIMEOUT cycles ending in err;
  // each is followed by exactly one DONE cycle with the client's pulse.
  task automatic run_txn(input logic [1:0] g,
                         input logic [15:0] a0, input logic [15:0] d0, input logic we0,
                         input logic [15:0] a1, input logic [15:0] d1, input logic we1,
                         input int w0, input int w1, input logic [15:0] rv);
    logic [15:0] ea, ed;
    logic        ewe;
    int          w, len;
    c0_addr = a0; c0_wdata = d0; c0_we = we0;
    c1_addr = a1; c1_wdata = d1; c1_we = we1;
    mem_ready = 1'b0;
    grant = g;
    tick();
    grant = 2'b00;
    c0_addr = 16'($urandom); c0_wdata = 16'($urandom); c0_we = 1'($urandom);
    c1_addr = 16'($urandom); c1_wdata = 16'($urandom); c1_we = 1'($urandom);
    for (int c = 0; c < 2; c++) begin
      if (g[c]) begin
        w   = (c == 0) ? w0 : w1;
        ea  = (c == 0) ? a0 : a1;
        ed  = (c == 0) ? d0 : d1;
        ewe = (c == 0) ? we0 : we1;
        len = (w < TO) ? w + 1 : TO;
        for (int k = 0; k < len; k++) begin
          chk("serve_req", 32'(mem_req), 32'd1);
          chk("serve_busy", 32'(busy), 32'd1);
          chk("serve_addr", 32'(mem_addr), 32'(ea));
          chk("serve_wdata", 32'(mem_wdata), 32'(ed));
          chk("serve_we", 32'(mem_we), 32'(ewe));
          chk("serve_done", 32'({c1_done, c0_done}), 32'd0);
          chk("serve_err", 32'(err), 32'd0);
          chk("serve_rdata", 32'(rdata), 32'(exp_rdata));
          mem_ready = (k == w);
          mem_rdata = (k == w) ? rv : 16'($urandom);
          if (k == w && !ewe) exp_rdata = rv;
          tick();
        end
        mem_ready = 1'($urandom);
        mem_rdata = 16'($urandom);
        chk("done_req", 32'(mem_req), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_c0", 32'(c0_done), 32'(c == 0));
        chk("done_c1", 32'(c1_done), 32'(c == 1));
        chk("done_err", 32'(err), 32'(w >= TO));
        chk("done_rdata", 32'(rdata), 32'(exp_rdata));
        tick();
      end
    end
    mem_ready = 1'b0;
    chk_quiet("idle");
    chk("idle_rdata", 32'(rdata), 32'(exp_rdata));
  endtask

  initial begin
    vecs[0] = '{2'b01, 16'h3000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 0, 16'hBEEF, 16'hBEEF};
    vecs[1] = '{2'b11, 16'h0010, 16'h1234, 1'b1, 16'h0020, 16'h0000, 1'b0, 0, 0, 16'h00AA, 16'h00AA};
    vecs[2] = '{2'b10, 16'h0000, 16'h0000, 1'b0, 16'h4000, 16'h5555, 1'b1, 0, 3, 16'h7777, 16'h00AA};
    vecs[3] = '{2'b10, 16'h0000, 16'h0000, 1'b0, 16'h4002, 16'h0000, 1'b0, 0, 3, 16'h1357, 16'h1357};
    vecs[4] = '{2'b01, 16'h1111, 16'h2222, 1'b0, 16'h0000, 16'h0000, 1'b0, 99, 0, 16'hDEAD, 16'h1357};
    vecs[5] = '{2'b01, 16'h1111, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 14, 0, 16'h4321, 16'h4321};
    vecs[6] = '{2'b11, 16'h0030, 16'h0000, 1'b0, 16'h0040, 16'h9999, 1'b1, 3, 0, 16'h2468, 16'h2468};
    vecs[7] = '{2'b11, 16'h0001, 16'h0000, 1'b1, 16'h0002, 16'h0000, 1'b0, 99, 99, 16'hACED, 16'h2468};

    // Reset held for 5 cycles, then 10 idle cycles with grant=00.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_quiet("rst");
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_addr", 32'({mem_addr, mem_wdata}), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_quiet("post_rst");
      chk("post_rst_rdata", 32'(rdata), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].g, vecs[i].a0, vecs[i].d0, vecs[i].we0, vecs[i].a1, vecs[i].d1,
              vecs[i].we1, vecs[i].w0, vecs[i].w1, vecs[i].rv);
      chk("vec_final_rdata", 32'(rdata), 32'(vecs[i].exp_rd));
      tick();
    end

    // Reset pulse during a wait state with both clients granted.
    c0_addr = 16'h0A0A; c0_we = 1'b0; c1_addr = 16'h0B0B; c1_we = 1'b0;
    grant = 2'b11;
    tick();
    grant = 2'b00;
    mem_ready = 1'b0;
    tick();
    tick();
    chk("wait_req", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_rdata", 32'(rdata), 32'd0);
    chk("async_rst_addr", 32'({mem_addr, mem_wdata}), 32'd0);
    tick();
    chk_quiet("rst_hold");
    reset = 1'b1;
    exp_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("after_abort");
    end
    run_txn(2'b10, 16'h0, 16'h0, 1'b0, 16'h5A5A, 16'h0, 1'b0, 1, 0, 16'hC0DE);
    chk("abort_recover_rdata", 32'(rdata), 32'hC0DE);

    // Randomized transactions, including boundary wait counts around TIMEOUT.
    for (int i = 0; i < 30; i++) begin
      int r0, r1;
      logic [1:0] g;
      g = 2'($urandom_range(1, 3));
      r0 = $urandom_range(0, 9);
      r1 = $urandom_range(0, 9);
      if (r0 > 6) r0 = (r0 == 7) ? TO - 1 : (r0 == 8) ? TO : 4;
      if (r1 > 6) r1 = (r1 == 7) ? TO - 1 : (r1 == 8) ? TO : 2;
      run_txn(g, 16'($urandom), 16'($urandom), 1'($urandom),
              16'($urandom), 16'($urandom), 1'($urandom), r0, r1, 16'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        tick();
        chk_quiet("gap");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/arb_grant_sequencer.md
# arb_grant_sequencer

Downstream consumer of the two-client arbiter's 2-bit `grant`. Latches each granted client's command, runs the commands one at a time on the shared LC-3 memory port with a ready handshake, and returns read data plus a one-cycle completion pulse to each client. When both grant bits are set, it serializes the commands: client 0 first, then client 1. A timeout guard prevents a dead memory from hanging the bus.

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `TIMEOUT`, 15, maximum cycles `mem_req` may wait for `mem_ready` (range 1–255)

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = in reset)
- `grant`  in  2  arbiter grant; bit0 = client 0, bit1 = client 1
- `c0_addr` / `c1_addr`  in  ADDR_W  client command address
- `c0_wdata` / `c1_wdata`  in  DATA_W  client write data
- `c0_we` / `c1_we`  in  1  1 = write, 0 = read
- `mem_req`  out  1  memory request valid
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_we`  out  1  memory write enable
- `mem_ready`  in  1  memory accepts/completes the current request
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ready`=1
- `c0_done` / `c1_done`  out  1  one-cycle completion pulse
- `rdata`  out  DATA_W  captured read data for the last completed read
- `err`  out  1  one-cycle pulse, coincident with `done`, on timeout
- `busy`  out  1  1 whenever state ≠ IDLE

## Operation
- Reset (`reset`=0, asynchronous): state goes to IDLE. `pending`=00, timeout counter=0. All outputs are 0: `mem_req`, `mem_addr`, `mem_wdata`, `mem_we`, both `done` pulses, `rdata`, `err`, `busy`.
- Reset asserted mid-transaction aborts the transaction immediately. No `done` pulse is issued for the aborted command.
- FSM states: IDLE, SERVE, DONE.
- IDLE:
  - If `grant`≠00 on a clock edge: latch `pending`←`grant`, latch both clients' addr/wdata/we, and go to SERVE.
  - `grant`=00 keeps the block in IDLE.
- SERVE:
  - Selected client = lowest set bit of `pending`.
  - Drive `mem_req`=1 with the selected client's latched addr/wdata/we, held stable for the whole state.
  - Timeout counter increments each cycle that `mem_ready`=0.
  - On `mem_ready`=1: for a read, capture `rdata`←`mem_rdata`; writes leave `rdata` unchanged. Then go to DONE.
  - If the counter reaches TIMEOUT with `mem_ready` still 0: go to DONE with the error flag set. `rdata` is unchanged.
- DONE:
  - `mem_req`=0.
  - Pulse the selected client's `done` (and `err` if flagged).
  - Clear that client's bit in `pending` and zero the counter.
  - Next state is SERVE if `pending` is still nonzero, otherwise IDLE.
- `grant` is ignored outside IDLE. A new grant arriving while busy is not queued.
- `mem_ready` is ignored outside SERVE.
- `rdata` holds its value until the next completed read.

## Timing
- Edge N samples `grant`≠00 in IDLE. `mem_req` and `busy` rise after edge N.
- Minimum transaction with `mem_ready` already 1 during the first SERVE cycle:
  - `done` is high for the cycle after edge N+1.
  - `busy` falls after edge N+2 (single client).
- Two clients with zero-wait memory:
  - c0: `mem_req` after N, `c0_done` after N+1.
  - c1: `mem_req` after N+2, `c1_done` after N+3.
  - IDLE after N+4.
- `mem_req` is always low for at least one cycle between transactions.
- Timeout: after TIMEOUT SERVE cycles with no ready, `done`+`err` are high in the next cycle.
- A `mem_ready` arriving in the same cycle the counter reaches TIMEOUT counts as success (ready wins).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset held for 5 cycles, then released with `grant`=00 → all outputs 0, `busy`=0 for 10 cycles.
- `grant`=01, c0 read `c0_addr`=0x3000, memory returns 0xBEEF with zero wait → `mem_addr`=0x3000, `mem_we`=0, one `c0_done` pulse, `rdata`=0xBEEF, `c1_done` never asserted.
- `grant`=11, c0 write 0x1234 to 0x0010, c1 read 0x0020 returning 0x00AA:
  - Write issued first, then the read.
  - `mem_req` low for the cycle between them.
  - `c0_done` then `c1_done` two cycles apart; `rdata`=0x00AA.
- `grant`=10 with memory inserting 3 wait cycles → `mem_addr`/`mem_wdata`/`mem_we` stable across 4 SERVE cycles; `c1_done` on the cycle after `mem_ready`.
- `TIMEOUT`=15, `mem_ready` tied 0, `grant`=01 → `mem_req` high for exactly 15 cycles, then `c0_done`=`err`=1 for one cycle, `rdata` unchanged, `busy` returns to 0.
- `reset` pulled low for 1 cycle during a wait state with `grant`=11 → outputs 0 immediately, no `done` pulses, and the next `grant`=10 is served normally.
